// File: rtl/rx_pack_pkg.sv
// Shared types and constants for the RX sample packer: FSM state encoding,
// output-word width derivation and the stall-counter width.
package rx_pack_pkg;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } pack_state_e;

    function automatic int calc_out_w(input int dsp_width, input int pack);
        return 2 * dsp_width * pack;
    endfunction

endpackage

// File: rtl/rx_pack_lane_acc.sv
// Sample accumulator for the RX packer: collects PACK {Q,I} samples, lane 0 in
// the LSBs, and presents the completed word on the beat of the final sample.
module rx_pack_lane_acc
    import rx_pack_pkg::*;
#(
    parameter int DSP_WIDTH = 16,
    parameter int PACK      = 2,
    parameter int LANE_W    = (PACK > 1) ? $clog2(PACK) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   accept,
    input  logic [2*DSP_WIDTH-1:0]                 in_data,
    output logic [LANE_W-1:0]                      lane,
    output logic                                   last_lane,
    output logic                                   full,
    output logic [calc_out_w(DSP_WIDTH, PACK)-1:0] word
);

    localparam int SW    = 2 * DSP_WIDTH;
    localparam int OUT_W = calc_out_w(DSP_WIDTH, PACK);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

    logic [OUT_W-1:0]  acc_r;
    logic [LANE_W-1:0] lane_r;

    assign lane      = lane_r;
    assign last_lane = (lane_r == LAST_LANE);
    assign full      = accept && last_lane;

    // The top lane comes straight from the input so the word is complete on the accepting beat
    always_comb begin
        word               = acc_r;
        word[OUT_W-1 -: SW] = in_data;
    end

    // Lane storage and lane index advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= '0;
            lane_r <= '0;
        end else if (accept) begin
            acc_r[lane_r*SW +: SW] <= in_data;
            lane_r                 <= last_lane ? '0 : lane_r + 1'b1;
        end
    end

endmodule

// File: rtl/rx_sample_packer.sv
// RX sample packer: packs PACK IQ samples per word and frames words into bursts
// with out_last. Optional burst header with sample timestamp: RX_SAMPLE_PACKER_TS_EN.
module rx_sample_packer
    import rx_pack_pkg::*;
#(
    parameter int DSP_WIDTH  = 16,
    parameter int PACK       = 2,
    parameter int BURST_BITS = 16,
    parameter int TS_WIDTH   = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [2*DSP_WIDTH-1:0]                 in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [calc_out_w(DSP_WIDTH, PACK)-1:0] out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    input  logic                                   cfg_enable,
    input  logic [BURST_BITS-1:0]                  cfg_burst_words,
    output logic [STALL_CNT_W-1:0]                 stat_stall_cnt,
    output logic                                   stat_active
);

    localparam int OUT_W  = calc_out_w(DSP_WIDTH, PACK);
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
`ifdef RX_SAMPLE_PACKER_TS_EN
    localparam pack_state_e BURST_ST = ST_HDR;
`else
    localparam pack_state_e BURST_ST = ST_RUN;
`endif

    pack_state_e           state_r, state_s;
    logic                  done_r, done_s;
    logic [BURST_BITS-1:0] len_r, wcnt_r, cfg_len_s;
    logic [TS_WIDTH-1:0]   samp_cnt_r;
    logic [STALL_CNT_W-1:0] stall_r;
    logic [OUT_W-1:0]      out_data_r, word_s;
    logic                  out_valid_r, out_last_r;
    logic [LANE_W-1:0]     lane_s;
    logic                  last_lane_s, full_s, accept_s, in_ready_s;
    logic                  word_last_s, boundary_s, out_free_s, mid_s;
`ifdef RX_SAMPLE_PACKER_TS_EN
    logic                  hdr_load_s;
`endif

    rx_pack_lane_acc #(
        .DSP_WIDTH (DSP_WIDTH),
        .PACK      (PACK),
        .LANE_W    (LANE_W)
    ) u_lane_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (accept_s),
        .in_data   (in_data),
        .lane      (lane_s),
        .last_lane (last_lane_s),
        .full      (full_s),
        .word      (word_s)
    );

    // done_r closes intake once the final word of a draining burst is loaded
    assign in_ready_s  = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) && !done_r &&
                         !(last_lane_s && out_valid_r && !out_ready);
    assign accept_s    = in_valid && in_ready_s;
    assign cfg_len_s   = (cfg_burst_words == '0) ? BURST_BITS'(1) : cfg_burst_words;
    assign word_last_s = (wcnt_r == (len_r - BURST_BITS'(1)));
    assign boundary_s  = full_s && word_last_s;
    assign out_free_s  = !out_valid_r || out_ready;
    assign mid_s       = (wcnt_r != '0) || (lane_s != '0) || accept_s;

    // Next-state logic
    always_comb begin
        state_s = state_r;
        done_s  = done_r;
`ifdef RX_SAMPLE_PACKER_TS_EN
        hdr_load_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (cfg_enable) state_s = BURST_ST;
                else            state_s = ST_IDLE;
            end
`ifdef RX_SAMPLE_PACKER_TS_EN
            ST_HDR: begin
                if (!cfg_enable) begin
                    state_s = ST_IDLE;
                end else if (out_free_s) begin
                    hdr_load_s = 1'b1;
                    state_s    = ST_RUN;
                end else begin
                    state_s = ST_HDR;
                end
            end
`endif
            ST_RUN: begin
                if (boundary_s) begin
                    if (cfg_enable) begin
                        state_s = BURST_ST;
                    end else begin
                        state_s = ST_DRAIN;
                        done_s  = 1'b1;
                    end
                end else if (!cfg_enable) begin
                    state_s = mid_s ? ST_DRAIN : ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (done_r) begin
                    if (out_free_s) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b0;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else if (boundary_s) begin
                    done_s = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                done_s  = 1'b0;
            end
        endcase
    end

    // State register and burst length / word counter bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
            len_r   <= BURST_BITS'(1);
            wcnt_r  <= '0;
        end else begin
            state_r <= state_s;
            done_r  <= done_s;
            if ((state_r == ST_IDLE) && cfg_enable) begin
                len_r <= cfg_len_s;
            end else if (boundary_s) begin
                len_r  <= cfg_len_s;
                wcnt_r <= '0;
            end else if (full_s) begin
                wcnt_r <= wcnt_r + BURST_BITS'(1);
            end
        end
    end

    // Output register; in_ready guarantees it is free whenever a data word loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (full_s) begin
            out_data_r  <= word_s;
            out_valid_r <= 1'b1;
            out_last_r  <= word_last_s;
`ifdef RX_SAMPLE_PACKER_TS_EN
        end else if (hdr_load_s) begin
            out_data_r  <= OUT_W'(samp_cnt_r);
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
`endif
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    // Free-running sample counter and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt_r <= '0;
            stall_r    <= '0;
        end else begin
            if (accept_s) samp_cnt_r <= samp_cnt_r + TS_WIDTH'(1);
            if (cfg_enable && in_valid && !in_ready_s && (stall_r != '1))
                stall_r <= stall_r + STALL_CNT_W'(1);
        end
    end

    assign in_ready       = in_ready_s;
    assign out_data       = out_data_r;
    assign out_valid      = out_valid_r;
    assign out_last       = out_last_r;
    assign stat_stall_cnt = stall_r;
    assign stat_active    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_rx_sample_packer.sv
// Directed self-checking bench for rx_sample_packer (PACK=2, 64-bit words).
// Sample k is {Q=k, I=k-1}; expected words are built from that rule.
module tb_rx_sample_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        cfg_enable = 1'b0;
    logic [15:0] cfg_burst_words = 16'd4;
    logic [15:0] stat_stall_cnt;
    logic        stat_active;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int samp_idx = 1;
    int samp_lim = 1;
    bit src_en   = 1'b0;
    bit acc_hs   = 1'b0;
    int obs_n    = 0;
    int obs_base = 0;
    logic [63:0] obs_data [0:63];
    logic        obs_last [0:63];
    int          obs_cyc  [0:63];
    int          acc_cyc  [0:127];
    bit          acc_at   [0:255];

    rx_sample_packer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .cfg_enable      (cfg_enable),
        .cfg_burst_words (cfg_burst_words),
        .stat_stall_cnt  (stat_stall_cnt),
        .stat_active     (stat_active)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] samp(input int k);
        return {16'(k), 16'(k - 1)};
    endfunction

    function automatic logic [63:0] exp_word(input int first);
        return {samp(first + 1), samp(first)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_words(input int n);
        int t;
        t = 0;
        while (((obs_n - obs_base) < n) && (t < 300)) begin
            tick();
            t++;
        end
        check("word_count", 64'(obs_n - obs_base), 64'(n));
    endtask

    task automatic start_burst(input int n_samp, input logic [15:0] len);
        obs_base        = obs_n;
        samp_lim        = samp_idx + n_samp;
        cfg_burst_words = len;
        cfg_enable      = 1'b1;
        src_en          = 1'b1;
    endtask

    task automatic stop_and_idle();
        cfg_enable = 1'b0;
        repeat (6) tick();
        src_en = 1'b0;
        tick();
    endtask

    task automatic check_words(input string tag, input int nw, input int base, input int len);
        for (int j = 0; j < nw; j++) begin
            check({tag, "_data"}, obs_data[obs_base + j], exp_word(base + 2 * j));
            check({tag, "_last"}, 64'(obs_last[obs_base + j]), 64'((j % len) == (len - 1)));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Handshake monitor, sampling mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            acc_hs = in_valid && in_ready;
            acc_at[cyc % 256] = acc_hs;
            if (acc_hs && (samp_idx < 128)) acc_cyc[samp_idx] = cyc;
            if (out_valid && out_ready && (obs_n < 64)) begin
                obs_data[obs_n] = out_data;
                obs_last[obs_n] = out_last;
                obs_cyc[obs_n]  = cyc;
                obs_n++;
            end
        end
    end

    // Sample source
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (acc_hs) samp_idx++;
            in_valid = src_en && (samp_idx < samp_lim);
            in_data  = samp(samp_idx);
        end
    end

    initial begin
        int base;
        int t;
        logic [63:0] hold;

        #3;
        check("rst_in_ready",  64'(in_ready),       64'd0);
        check("rst_out_valid", 64'(out_valid),      64'd0);
        check("rst_out_last",  64'(out_last),       64'd0);
        check("rst_out_data",  out_data,            64'd0);
        check("rst_stall",     64'(stat_stall_cnt), 64'd0);
        check("rst_active",    64'(stat_active),    64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

`ifndef RX_SAMPLE_PACKER_TS_EN
        // 1: basic packing, L=4
        base = samp_idx;
        start_burst(8, 16'd4);
        wait_words(4);
        check_words("t1", 4, base, 4);
        check("t1_latency", 64'(obs_cyc[obs_base]), 64'(acc_cyc[base + 1] + 1));
        check("t1_stall", 64'(stat_stall_cnt), 64'd0);
        stop_and_idle();
        check("t1_active", 64'(stat_active), 64'd0);

        // 2: sink backpressure for 10 cycles after the first word loads
        base = samp_idx;
        start_burst(8, 16'd4);
        t = 0;
        while (!out_valid && (t < 50)) begin
            tick();
            t++;
        end
        check("t2_ovalid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        hold = out_data;
        repeat (9) tick();
        check("t2_hold_data",  out_data,         hold);
        check("t2_hold_valid", 64'(out_valid),   64'd1);
        check("t2_in_ready",   64'(in_ready),    64'd0);
        tick();
        out_ready = 1'b1;
        wait_words(4);
        check_words("t2", 4, base, 4);
        check("t2_stall", 64'(stat_stall_cnt), 64'd9);
        stop_and_idle();
        check("t2_active", 64'(stat_active), 64'd0);

        // 3: disable mid-burst drains exactly the burst
        base = samp_idx;
        start_burst(12, 16'd4);
        wait_words(2);
        cfg_enable = 1'b0;
        check("t3_active_drain", 64'(stat_active), 64'd1);
        wait_words(4);
        repeat (6) tick();
        check_words("t3", 4, base, 4);
        check("t3_nwords",   64'(obs_n - obs_base), 64'd4);
        check("t3_consumed", 64'(samp_idx - base),  64'd8);
        check("t3_active",   64'(stat_active),      64'd0);
        check("t3_in_ready", 64'(in_ready),         64'd0);
        src_en = 1'b0;
        tick();

        // 4: burst length 0 behaves as 1
        base = samp_idx;
        start_burst(6, 16'd0);
        wait_words(3);
        check_words("t4", 3, base, 1);
        stop_and_idle();

        // 5: asynchronous reset mid-word
        start_burst(3, 16'd4);
        out_ready = 1'b0;
        t = 0;
        while ((samp_idx < samp_lim) && (t < 50)) begin
            tick();
            t++;
        end
        tick();
        check("t5_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", 64'(out_valid),      64'd0);
        check("t5_out_data",  out_data,            64'd0);
        check("t5_out_last",  64'(out_last),       64'd0);
        check("t5_in_ready",  64'(in_ready),       64'd0);
        check("t5_stall",     64'(stat_stall_cnt), 64'd0);
        check("t5_active",    64'(stat_active),    64'd0);
        cfg_enable = 1'b0;
        src_en     = 1'b0;
        out_ready  = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        base = samp_idx;
        start_burst(8, 16'd4);
        wait_words(4);
        check_words("t5", 4, base, 4);
        stop_and_idle();
`else
        // 6: header word before every burst, L=2
        base = samp_idx;
        start_burst(8, 16'd2);
        wait_words(6);
        check("t6_hdr0_data", obs_data[obs_base],          64'd0);
        check("t6_hdr0_last", 64'(obs_last[obs_base]),     64'd0);
        check("t6_w0_data",   obs_data[obs_base + 1],      exp_word(base));
        check("t6_w0_last",   64'(obs_last[obs_base + 1]), 64'd0);
        check("t6_w1_data",   obs_data[obs_base + 2],      exp_word(base + 2));
        check("t6_w1_last",   64'(obs_last[obs_base + 2]), 64'd1);
        check("t6_hdr1_data", obs_data[obs_base + 3],      64'd4);
        check("t6_hdr1_last", 64'(obs_last[obs_base + 3]), 64'd0);
        check("t6_w2_data",   obs_data[obs_base + 4],      exp_word(base + 4));
        check("t6_w2_last",   64'(obs_last[obs_base + 4]), 64'd0);
        check("t6_w3_data",   obs_data[obs_base + 5],      exp_word(base + 6));
        check("t6_w3_last",   64'(obs_last[obs_base + 5]), 64'd1);
        check("t6_hdr0_noacc", 64'(acc_at[(obs_cyc[obs_base] - 1) % 256]),     64'd0);
        check("t6_hdr1_noacc", 64'(acc_at[(obs_cyc[obs_base + 3] - 1) % 256]), 64'd0);
        stop_and_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
